// File: rtl/bcd_serial_adder_if.sv
// Handshake and operand/result bundle for the digit-serial BCD adder.
// The master drives the request and operands; the slave returns status and results.
interface bcd_serial_adder_if #(
    parameter int DIGITS = 4
);
    logic                  start;
    logic                  sub;
    logic                  c_in;
    logic [4*DIGITS-1:0]   A;
    logic [4*DIGITS-1:0]   B;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   sum;
    logic                  c_out;
    logic                  err;

    modport master (
        output start, sub, c_in, A, B,
        input  busy, done, sum, c_out, err
    );

    modport slave (
        input  start, sub, c_in, A, B,
        output busy, done, sum, c_out, err
    );
endinterface

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder/subtractor: one decimal digit per clock, LSD first.
// Subtraction adds the nine's complement of B with an initial carry of one.
module bcd_serial_adder #(
    parameter int DIGITS = 4,
    parameter int IDXW   = 2
) (
    input  logic                Clock,
    input  logic                Resetn,
    bcd_serial_adder_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t              state;
    state_t              next_state;

    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [4*DIGITS-1:0] sum_q;
    logic                sub_q;
    logic                carry_q;
    logic                c_out_q;
    logic                err_q;
    logic [IDXW-1:0]     idx_q;

    logic                last_digit;
    logic [3:0]          a_dig;
    logic [3:0]          b_dig;
    logic [3:0]          b_eff;
    logic [4:0]          d_raw;
    logic [4:0]          d_adj;
    logic [3:0]          sum_dig;
    logic                carry_nxt;
    logic                dig_err;

    assign last_digit = (idx_q == IDXW'(DIGITS - 1));

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = ADD;
            ADD:     if (last_digit) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One decimal digit step: a + b' + carry, corrected back into 0..9 when it overflows.
    always_comb begin
        a_dig     = a_q[{idx_q, 2'b00} +: 4];
        b_dig     = b_q[{idx_q, 2'b00} +: 4];
        b_eff     = sub_q ? (4'd9 - b_dig) : b_dig;
        d_raw     = {1'b0, a_dig} + {1'b0, b_eff} + {4'b0000, carry_q};
        d_adj     = d_raw - 5'd10;
        sum_dig   = d_raw[3:0];
        carry_nxt = 1'b0;
        if (d_raw > 5'd9) begin
            sum_dig   = d_adj[3:0];
            carry_nxt = 1'b1;
        end
        dig_err   = (a_dig > 4'd9) | (b_dig > 4'd9);
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.A;
                        b_q     <= bus.B;
                        sub_q   <= bus.sub;
                        carry_q <= bus.sub ? 1'b1 : bus.c_in;
                        idx_q   <= '0;
                        err_q   <= 1'b0;
                        sum_q   <= '0;
                    end
                end
                ADD: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= sum_dig;
                    carry_q <= carry_nxt;
                    err_q   <= err_q | dig_err;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_digit) begin
                        c_out_q <= carry_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy  = (state == ADD) || (state == DONE);
    assign bus.done  = (state == DONE);
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomised self-checking bench for bcd_serial_adder against a decimal reference model.
module tb_bcd_serial_adder;

    localparam int DIGITS = 4;
    localparam int IDXW   = 2;
    localparam int W      = 4 * DIGITS;

    logic Clock;
    logic Resetn;
    int   checks;
    int   errors;

    bcd_serial_adder_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_adder #(.DIGITS(DIGITS), .IDXW(IDXW)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Valid operands go through plain decimal arithmetic; invalid digits fall back to the digit rule.
    function automatic void refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input bit sb, input bit cn,
                                     output logic [W-1:0] s, output bit co, output bit er);
        int av, bv, r, modv, carry;
        logic [3:0] da, db, bd;
        logic [4:0] d;
        av = 0; bv = 0; er = 0; modv = 1; s = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            da = a[4*i +: 4];
            db = b[4*i +: 4];
            if (da > 9 || db > 9) er = 1;
            av = av * 10 + int'(da);
            bv = bv * 10 + int'(db);
            modv = modv * 10;
        end
        if (!er) begin
            if (sb) begin
                r  = av - bv;
                co = (r >= 0);
                if (r < 0) r += modv;
            end else begin
                r  = av + bv + int'(cn);
                co = (r >= modv);
                if (co) r -= modv;
            end
            for (int i = 0; i < DIGITS; i++) begin
                s[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            carry = sb ? 1 : int'(cn);
            for (int i = 0; i < DIGITS; i++) begin
                da = a[4*i +: 4];
                db = b[4*i +: 4];
                bd = sb ? (4'd9 - db) : db;
                d  = 5'(int'(da) + int'(bd) + carry);
                if (d > 9) begin
                    s[4*i +: 4] = 4'(int'(d) - 10);
                    carry = 1;
                end else begin
                    s[4*i +: 4] = d[3:0];
                    carry = 0;
                end
            end
            co = (carry != 0);
        end
    endfunction

    // Runs one operation over a fixed observation window; optional corner behaviours.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit sb, input bit cn,
                                 input bit zeroA, input bit repulse, input string tag);
        logic [W-1:0] es;
        bit eco, eer;
        int dones, doneAt, busyCycles;
        refModel(a, b, sb, cn, es, eco, eer);
        bus.A = a; bus.B = b; bus.sub = sb; bus.c_in = cn; bus.start = 1'b1;
        @(posedge Clock); #1;
        bus.start = 1'b0;
        if (zeroA) bus.A = '0;
        bus.c_in = ~cn;
        dones = 0; doneAt = 0; busyCycles = 0;
        for (int k = 1; k <= DIGITS + 3; k++) begin
            bus.start = (repulse && k == 2);
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                dones++;
                doneAt = k;
                checkOutput({tag, ".sum@done"}, 32'(bus.sum), 32'(es));
            end
            @(posedge Clock); #1;
        end
        bus.start = 1'b0;
        checkOutput({tag, ".doneCount"}, 32'(dones), 32'd1);
        checkOutput({tag, ".latency"}, 32'(doneAt), 32'(DIGITS + 1));
        checkOutput({tag, ".busyCycles"}, 32'(busyCycles), 32'(DIGITS + 1));
        checkOutput({tag, ".sumHeld"}, 32'(bus.sum), 32'(es));
        checkOutput({tag, ".c_out"}, 32'(bus.c_out), 32'(eco));
        checkOutput({tag, ".err"}, 32'(bus.err), 32'(eer));
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".busy"}, 32'(bus.busy), 32'd0);
        checkOutput({tag, ".done"}, 32'(bus.done), 32'd0);
        checkOutput({tag, ".sum"}, 32'(bus.sum), 32'd0);
        checkOutput({tag, ".c_out"}, 32'(bus.c_out), 32'd0);
        checkOutput({tag, ".err"}, 32'(bus.err), 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int dones;
        checks = 0; errors = 0;
        bus.start = 1'b0; bus.sub = 1'b0; bus.c_in = 1'b0; bus.A = '0; bus.B = '0;
        Resetn = 1'b0;
        #3;
        checkAllZero("resetAsserted");
        #9;
        Resetn = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        checkAllZero("idleAfterReset");

        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, 1'b0, 1'b0, "add");
        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b1, 1'b0, 1'b0, "addCin");
        applyStimulus(16'h9999, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, "ripple");
        applyStimulus(16'h9999, 16'h9999, 1'b0, 1'b1, 1'b0, 1'b0, "rippleMax");
        applyStimulus(16'h0500, 16'h0123, 1'b1, 1'b1, 1'b0, 1'b0, "subPos");
        applyStimulus(16'h0123, 16'h0500, 1'b1, 1'b1, 1'b0, 1'b0, "subNeg");
        applyStimulus(16'h00A0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, "errA");
        applyStimulus(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, "errClear");
        applyStimulus(16'h4321, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1, "restartIgnored");
        applyStimulus(16'h2468, 16'h1357, 1'b1, 1'b0, 1'b1, 1'b0, "latchedA");

        // Abandon an operation part-way: partial sum digits must vanish at once.
        bus.A = 16'h1234; bus.B = 16'h5678; bus.sub = 1'b0; bus.c_in = 1'b0; bus.start = 1'b1;
        @(posedge Clock); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge Clock);
        #3;
        Resetn = 1'b0;
        #1;
        checkAllZero("midOpReset");
        @(posedge Clock); #3;
        Resetn = 1'b1;
        dones = 0;
        for (int k = 0; k < DIGITS + 3; k++) begin
            @(posedge Clock); #1;
            if (bus.done) dones++;
        end
        checkOutput("midOpReset.noDone", 32'(dones), 32'd0);
        checkAllZero("afterMidOpReset");
        applyStimulus(16'h0042, 16'h0058, 1'b0, 1'b0, 1'b0, 1'b0, "postReset");

        for (int n = 0; n < 30; n++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
        end
        for (int n = 0; n < 6; n++) begin
            ra = W'($urandom_range(0, 65535));
            rb = W'($urandom_range(0, 65535));
            rb[3:0] = 4'hC;
            applyStimulus(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'b0, 1'b0, "randInvalid");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
